// File: rtl/bp_be_dcache_lce_resp_arb.sv
// Arbitrates LCE responses from the request and command engines into a single
// registered output buffer. The request engine has priority, with an anti-starvation override for the command engine.
module bp_be_dcache_lce_resp_arb #(
    parameter int resp_width_p   = 64,
    parameter int starve_limit_p = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic [resp_width_p-1:0] req_resp_i,
    input  logic                    req_resp_v_i,
    output logic                    req_resp_yumi_o,

    input  logic [resp_width_p-1:0] cmd_resp_i,
    input  logic                    cmd_resp_v_i,
    output logic                    cmd_resp_yumi_o,

    output logic [resp_width_p-1:0] lce_resp_o,
    output logic                    lce_resp_v_o,
    input  logic                    lce_resp_ready_i
);

    localparam logic [3:0] starve_limit = 4'(starve_limit_p);

    logic [resp_width_p-1:0] data_reg;
    logic                    valid_reg;
    logic [3:0]              starve_reg;
    logic [3:0]              starve_next;

    logic buf_open;
    logic force_cmd;
    logic cmd_win;
    logic req_grant;
    logic cmd_grant;

    always_comb begin
        buf_open  = !valid_reg || lce_resp_ready_i;
        force_cmd = (starve_reg == starve_limit);
        cmd_win   = cmd_resp_v_i && (force_cmd || !req_resp_v_i);
        // Grants are gated by reset so both yumis drop immediately when reset asserts.
        cmd_grant = reset_n_i && buf_open && cmd_win;
        req_grant = reset_n_i && buf_open && req_resp_v_i && !cmd_win;

        starve_next = starve_reg;
        if (cmd_grant || !cmd_resp_v_i) begin
            starve_next = '0;
        end else if (req_grant && (starve_reg != starve_limit)) begin
            starve_next = starve_reg + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_reg   <= '0;
            valid_reg  <= 1'b0;
            starve_reg <= '0;
        end else begin
            starve_reg <= starve_next;
            // An open buffer either refills from the winner or empties.
            if (buf_open) begin
                valid_reg <= req_grant || cmd_grant;
                if (cmd_grant) begin
                    data_reg <= cmd_resp_i;
                end else if (req_grant) begin
                    data_reg <= req_resp_i;
                end
            end
        end
    end

    assign req_resp_yumi_o = req_grant;
    assign cmd_resp_yumi_o = cmd_grant;
    assign lce_resp_o      = data_reg;
    assign lce_resp_v_o    = valid_reg;

endmodule

// File: tb/tb_bp_be_dcache_lce_resp_arb.sv
// Directed and randomized-scoreboard bench for bp_be_dcache_lce_resp_arb:
// reset behaviour, latency, priority/starvation pattern, backpressure and async reset.
module tb_bp_be_dcache_lce_resp_arb;

    logic        clk;
    logic        reset_n;
    logic [63:0] req_resp;
    logic        req_v;
    logic        req_yumi;
    logic [63:0] cmd_resp;
    logic        cmd_v;
    logic        cmd_yumi;
    logic [63:0] lce_resp;
    logic        lce_v;
    logic        ready;

    int tests  = 0;
    int failed = 0;

    logic [63:0] req_pkt;
    logic [63:0] cmd_pkt;
    logic [63:0] hold_exp;
    logic [63:0] rq[$];
    logic [63:0] cq[$];

    bp_be_dcache_lce_resp_arb #(
        .resp_width_p  (64),
        .starve_limit_p(4)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .req_resp_i      (req_resp),
        .req_resp_v_i    (req_v),
        .req_resp_yumi_o (req_yumi),
        .cmd_resp_i      (cmd_resp),
        .cmd_resp_v_i    (cmd_v),
        .cmd_resp_yumi_o (cmd_yumi),
        .lce_resp_o      (lce_resp),
        .lce_resp_v_o    (lce_v),
        .lce_resp_ready_i(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Both/either sources valid with ready=1; bit i of exp_cmd says cmd wins cycle i.
    task automatic run_seq(input int n, input logic [15:0] cmdv, input logic [15:0] exp_cmd);
        logic [63:0] exp_pkt;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_v    = 1'b1;
            cmd_v    = cmdv[i];
            ready    = 1'b1;
            req_resp = req_pkt;
            cmd_resp = cmd_pkt;
            #1;
            chk($sformatf("req_yumi[%0d]", i), {63'd0, req_yumi}, {63'd0, !exp_cmd[i]});
            chk($sformatf("cmd_yumi[%0d]", i), {63'd0, cmd_yumi}, {63'd0, exp_cmd[i]});
            exp_pkt = exp_cmd[i] ? cmd_pkt : req_pkt;
            @(posedge clk);
            #1;
            chk($sformatf("seq_data[%0d]", i), lce_resp, exp_pkt);
            chk($sformatf("seq_v[%0d]", i), {63'd0, lce_v}, 64'd1);
            $display("[TB] seq %0d grant=%s pkt=%h", i, exp_cmd[i] ? "cmd" : "req", lce_resp);
            if (exp_cmd[i]) cmd_pkt = cmd_pkt + 64'd1;
            else            req_pkt = req_pkt + 64'd1;
        end
    endtask

    initial begin
        logic        got_r;
        logic        got_c;
        logic [63:0] exp;
        int          rseq;
        int          cseq;

        reset_n  = 1'b1;
        req_v    = 1'b0;
        cmd_v    = 1'b0;
        ready    = 1'b1;
        req_resp = '0;
        cmd_resp = '0;
        req_pkt  = 64'h1000;
        cmd_pkt  = 64'h2000;

        // Reset state, with both sources valid to prove yumis are suppressed
        #1 reset_n = 1'b0;
        req_v = 1'b1;
        cmd_v = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_v", {63'd0, lce_v}, 64'd0);
        chk("rst_data", lce_resp, 64'd0);
        chk("rst_req_yumi", {63'd0, req_yumi}, 64'd0);
        chk("rst_cmd_yumi", {63'd0, cmd_yumi}, 64'd0);

        // First grant right after reset release, latency 1
        @(negedge clk);
        reset_n  = 1'b1;
        cmd_v    = 1'b0;
        req_resp = 64'hA5;
        #1;
        chk("first_req_yumi", {63'd0, req_yumi}, 64'd1);
        chk("first_cmd_yumi", {63'd0, cmd_yumi}, 64'd0);
        @(posedge clk);
        #1;
        chk("first_data", lce_resp, 64'hA5);
        chk("first_v", {63'd0, lce_v}, 64'd1);
        $display("[TB] first grant pkt=%h", lce_resp);
        @(negedge clk);
        req_v = 1'b0;
        @(posedge clk);
        #1;
        chk("drain_empty_v", {63'd0, lce_v}, 64'd0);

        // Continuous contention: req x4 then forced cmd, repeating
        run_seq(10, 16'h03FF, 16'h0210);

        // Backpressure for 3 cycles holds output and blocks both sources
        hold_exp = cmd_pkt - 64'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_v    = 1'b1;
            cmd_v    = 1'b1;
            ready    = 1'b0;
            req_resp = req_pkt;
            cmd_resp = cmd_pkt;
            #1;
            chk($sformatf("bp_req_yumi[%0d]", i), {63'd0, req_yumi}, 64'd0);
            chk($sformatf("bp_cmd_yumi[%0d]", i), {63'd0, cmd_yumi}, 64'd0);
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold[%0d]", i), lce_resp, hold_exp);
            chk($sformatf("bp_v[%0d]", i), {63'd0, lce_v}, 64'd1);
            $display("[TB] backpressure %0d pkt=%h", i, lce_resp);
        end
        // Release: drain and refill in the same cycle
        run_seq(1, 16'h0001, 16'h0000);

        // cmd loses twice, drops (counter restarts), then 4 more req wins before force
        run_seq(7, 16'h007D, 16'h0040);

        // Async reset pulse between edges with buffer full
        @(negedge clk);
        req_v    = 1'b1;
        cmd_v    = 1'b1;
        ready    = 1'b0;
        req_resp = req_pkt;
        cmd_resp = cmd_pkt;
        #1 reset_n = 1'b0;
        #1;
        chk("async_v", {63'd0, lce_v}, 64'd0);
        chk("async_data", lce_resp, 64'd0);
        chk("async_req_yumi", {63'd0, req_yumi}, 64'd0);
        chk("async_cmd_yumi", {63'd0, cmd_yumi}, 64'd0);
        #1 reset_n = 1'b1;
        #1;
        chk("post_rst_req_yumi", {63'd0, req_yumi}, 64'd1);
        @(posedge clk);
        #1;
        chk("post_rst_data", lce_resp, req_pkt);
        chk("post_rst_v", {63'd0, lce_v}, 64'd1);
        $display("[TB] after async reset pkt=%h", lce_resp);

        // Randomized traffic with per-source scoreboard
        @(negedge clk);
        reset_n = 1'b0;
        req_v   = 1'b0;
        cmd_v   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rseq    = 0;
        cseq    = 0;
        got_r   = 1'b0;
        got_c   = 1'b0;
        req_pkt = 64'hA000_0000_0000_0000;
        cmd_pkt = 64'hC000_0000_0000_0000;
        for (int cyc = 0; cyc < 440; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (got_r) begin
                rseq++;
                req_pkt = 64'hA000_0000_0000_0000 | 64'(rseq);
                req_v   = 1'b0;
            end
            if (got_c) begin
                cseq++;
                cmd_pkt = 64'hC000_0000_0000_0000 | 64'(cseq);
                cmd_v   = 1'b0;
            end
            if (cyc < 400) begin
                if (!req_v) req_v = ($urandom_range(0, 2) != 0);
                if (!cmd_v) cmd_v = ($urandom_range(0, 2) != 0);
                ready = ($urandom_range(0, 3) != 0);
            end else begin
                ready = 1'b1;
            end
            req_resp = req_pkt;
            cmd_resp = cmd_pkt;
            #1;
            chk("rand_invariant",
                {63'd0, (req_yumi && !req_v) || (cmd_yumi && !cmd_v) || (req_yumi && cmd_yumi)},
                64'd0);
            if (lce_v && ready) begin
                if (lce_resp[63:60] == 4'hA) begin
                    exp = (rq.size() > 0) ? rq.pop_front() : '1;
                    chk("sb_req", lce_resp, exp);
                end else begin
                    exp = (cq.size() > 0) ? cq.pop_front() : '1;
                    chk("sb_cmd", lce_resp, exp);
                end
                $display("[TB] rand cyc %0d out=%h", cyc, lce_resp);
            end
            if (req_yumi) rq.push_back(req_pkt);
            if (cmd_yumi) cq.push_back(cmd_pkt);
            got_r = req_yumi;
            got_c = cmd_yumi;
            @(posedge clk);
        end
        chk("sb_leftover", 64'(rq.size() + cq.size()), 64'd0);
        chk("sb_all_req_sent", {63'd0, req_v}, 64'd0);
        chk("sb_all_cmd_sent", {63'd0, cmd_v}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
